// File: rtl/stream_minmax_signed.sv
// Streaming signed min/max over fixed-length frames, with valid/ready on both sides.
// Optional STREAM_MINMAX_INDEX_EN adds o_min_idx/o_max_idx (frame position of the winners).
//
// state | meaning
// IDLE  | no sample of the current frame taken yet
// ACCUM | at least one sample taken, frame incomplete
// DONE  | complete result held until the consumer takes it
module stream_minmax_signed #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_min,
  output logic [WIDTH-1:0] o_max,
  output logic             o_valid,
  input  logic             i_ready
`ifdef STREAM_MINMAX_INDEX_EN
  ,
  output logic [((FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1)-1:0] o_min_idx,
  output logic [((FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1)-1:0] o_max_idx
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] min_q, max_q;
  logic             accept, last, handshake, lt_min, gt_max;

  // Two's-complement a < b without relying on signed types.
  function automatic logic slt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    return (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : d[WIDTH-1];
  endfunction

  assign o_ready   = !i_rst && (state != S_DONE);
  assign accept    = i_valid && o_ready;
  assign last      = (cnt == CW'(FRAME_LEN - 1));
  assign handshake = (state == S_DONE) && i_ready;
  assign lt_min    = slt(i_data, min_q);
  assign gt_max    = slt(max_q, i_data);

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: if (accept) state_nxt = last ? S_DONE : S_ACCUM;
        S_DONE:          if (i_ready) state_nxt = S_IDLE;
        default:         state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

`ifdef STREAM_MINMAX_INDEX_EN
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  logic [IW-1:0] min_idx_q, max_idx_q;
`endif

  // Counter holds at FRAME_LEN-1 in DONE; only the handshake or a flush clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      min_q <= '0;
      max_q <= '0;
`ifdef STREAM_MINMAX_INDEX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else if (i_flush || handshake) begin
      cnt <= '0;
    end else if (accept) begin
      if (state == S_IDLE) begin
        min_q <= i_data;
        max_q <= i_data;
`ifdef STREAM_MINMAX_INDEX_EN
        min_idx_q <= '0;
        max_idx_q <= '0;
`endif
      end else begin
        if (lt_min) begin
          min_q <= i_data;
`ifdef STREAM_MINMAX_INDEX_EN
          min_idx_q <= cnt[IW-1:0];
`endif
        end
        if (gt_max) begin
          max_q <= i_data;
`ifdef STREAM_MINMAX_INDEX_EN
          max_idx_q <= cnt[IW-1:0];
`endif
        end
      end
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  assign o_valid = (state == S_DONE) && !i_rst;
  assign o_min   = i_rst ? '0 : min_q;
  assign o_max   = i_rst ? '0 : max_q;
`ifdef STREAM_MINMAX_INDEX_EN
  assign o_min_idx = i_rst ? '0 : min_idx_q;
  assign o_max_idx = i_rst ? '0 : max_idx_q;
`endif

endmodule

// File: doc/stream_minmax_signed.md
STREAM_MINMAX_SIGNED -- requirements
Module: stream_minmax_signed

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample width, two's-complement signed, WIDTH >= 2.
REQ-002 SHALL have parameter FRAME_LEN, default 16: samples per frame, FRAME_LEN >= 1.
REQ-003 SHALL have port i_clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_data, input, WIDTH: sample value, signed.
REQ-006 SHALL have port i_valid, input, 1: i_data valid.
REQ-007 SHALL have port o_ready, output, 1: block accepts a sample.
REQ-008 SHALL have port i_flush, input, 1: abort the current frame.
REQ-009 SHALL have port o_min, output, WIDTH: frame minimum, signed.
REQ-010 SHALL have port o_max, output, WIDTH: frame maximum, signed.
REQ-011 SHALL have port o_valid, output, 1: o_min/o_max hold a complete frame result.
REQ-012 SHALL have port i_ready, input, 1: consumer accepts the result.

Function
REQ-013 SHALL use an FSM with states IDLE (no sample taken), ACCUM (at least one sample taken) and DONE (result held).
REQ-014 SHALL accept a sample only when i_valid and o_ready are both 1 on a rising edge.
REQ-015 SHALL drive o_ready = 1 in IDLE and ACCUM, and 0 in DONE and while i_rst = 1.
REQ-016 SHALL load the first accepted sample of a frame into both the min and max registers.
REQ-017 SHALL replace min when a later sample is strictly less than min, and max when max is strictly less than the sample, using signed compare (on sign mismatch, the negative operand is less; otherwise take the MSB of a - b).
REQ-018 SHALL keep the stored value on ties, so the earliest occurrence wins.
REQ-019 SHALL count accepted samples 0..FRAME_LEN-1.
REQ-020 SHALL enter DONE on the edge that accepts sample FRAME_LEN and assert o_valid from the next cycle, giving one cycle of latency after the last accept.
REQ-021 SHALL, for FRAME_LEN = 1, go from IDLE directly to DONE.
REQ-022 SHALL hold o_min, o_max and o_valid stable in DONE until i_ready = 1.
REQ-023 SHALL, on o_valid && i_ready, clear the counter and enter IDLE, with o_ready = 1 in the following cycle; there is no same-cycle accept/drain bypass.
REQ-024 SHALL make o_min/o_max outside DONE reflect the running registers, with no meaning while o_valid = 0.
REQ-025 SHALL, on i_flush = 1 in any state, go to IDLE next cycle with the counter cleared and o_valid = 0, and SHALL discard any sample offered in that cycle.
REQ-026 SHALL apply priority i_rst > i_flush > result handshake > sample accept.
REQ-027 SHALL size the counter $clog2(FRAME_LEN+1) bits and ensure it never wraps past FRAME_LEN-1.

Reset
REQ-028 SHALL, while i_rst = 1, force state IDLE, counter 0, o_min = 0, o_max = 0, o_valid = 0 and o_ready = 0.
REQ-029 SHALL, when i_rst is asserted mid-frame or in DONE, discard the partial or held result with no output emitted.
REQ-030 SHALL assert o_ready = 1 in the first cycle after i_rst deasserts.

Configuration
REQ-031 SHALL, with macro STREAM_MINMAX_INDEX_EN defined, add outputs o_min_idx and o_max_idx, each max(1,$clog2(FRAME_LEN)) bits.
REQ-032 SHALL make o_min_idx/o_max_idx the 0-based frame position of the winning sample, updated under the same rules as min/max, reset to 0 and held in DONE.
REQ-033 SHALL, without STREAM_MINMAX_INDEX_EN, omit the index ports and index registers, with all other behaviour identical.

Verification
REQ-034 SHALL cover (WIDTH=8, FRAME_LEN=4) inputs 0x05,0xFB,0x7F,0x80 back-to-back -> o_valid one cycle after the 4th accept, o_min=0x80, o_max=0x7F; with the index macro, idx 3 and 2.
REQ-035 SHALL cover inputs 0x03 x4 -> o_min=o_max=0x03; with the index macro, both idx=0.
REQ-036 SHALL cover inputs 0xFF,0x00,0x01,0xFE -> o_min=0xFE, o_max=0x01, confirming the sign boundary.
REQ-037 SHALL cover i_ready held 0 for 5 cycles in DONE -> outputs stable, o_ready=0, then IDLE and o_ready=1 the cycle after the handshake.
REQ-038 SHALL cover i_flush after 2 samples (0x80,0x7F), then frame 0x10,0x20,0x30,0x40 -> o_min=0x10, o_max=0x40.
REQ-039 SHALL cover i_rst after 3 accepts -> no o_valid, all outputs 0, and the next full frame produces the correct result.
